// File: rtl/rr_mux_stage.sv
// rr_mux_stage: registered N-to-1 round-robin mux stage with valid/ready on every input and the output.
// Optional packet locking is enabled by defining RR_MUX_STAGE_PKT_LOCK_EN (adds in_last/out_last).
module rr_mux_stage #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in_valid,
   input  logic [N*W-1:0]       in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_sel,
`ifdef RR_MUX_STAGE_PKT_LOCK_EN
   input  logic [N-1:0]         in_last,
   output logic                 out_last,
`endif
   input  logic                 out_ready
);

   localparam int SW = $clog2(N);

   logic          load;
   logic [N-1:0]  req;
   logic [N-1:0]  rot;
   logic          grant_vld;
   logic [SW-1:0] grant;
   logic [SW-1:0] grant_nxt;
   logic [SW-1:0] ptr;
   logic [W-1:0]  sel_data;

   assign load = !out_valid || out_ready;

`ifdef RR_MUX_STAGE_PKT_LOCK_EN
   logic locked;

   // While a packet is open only its owner may request; out_sel always names that owner.
   always_comb begin
      req = in_valid;
      if (locked)
         req = in_valid & (N'(1) << out_sel);
   end
`else
   assign req = in_valid;
`endif

   // Rotate so that bit 0 is the channel at the priority pointer.
   assign rot = N'({req, req} >> ptr);

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!grant_vld && rot[k]) begin
            grant_vld = 1'b1;
            grant     = SW'((32'(ptr) + k) % N);
         end
      end
   end

   assign grant_nxt = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SW'(i))
            sel_data = in_data[i*W +: W];
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load && grant_vld)
         in_ready = N'(1) << grant;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
`ifdef RR_MUX_STAGE_PKT_LOCK_EN
         out_last  <= 1'b0;
         locked    <= 1'b0;
`endif
      end else if (load) begin
         if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
`ifdef RR_MUX_STAGE_PKT_LOCK_EN
            out_last  <= in_last[grant];
            locked    <= !in_last[grant];
            if (in_last[grant])
               ptr <= grant_nxt;
`else
            ptr       <= grant_nxt;
`endif
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rr_mux_stage.md
Name: rr_mux_stage

Overview:
- Registered N-to-1 multiplexer stage with valid/ready handshakes on every input and on the output.
- A round-robin arbiter chooses one requesting channel per cycle and drives the mux select.
- The chosen word is captured in a single output register.
- Sits upstream of the combinational mux/gate blocks. Its out_sel and out_data feed them directly, so a streaming source can be time-multiplexed into one combinational consumer.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel.
- SW, $clog2(N), select width (derived, not overridable).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  one-hot or zero; bit i high means channel i's word is accepted this cycle.
- out_valid  output  1  out_data/out_sel hold a valid word.
- out_data  output  W  registered selected data.
- out_sel  output  SW  index of the channel that produced out_data.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0.
  - in_ready=0 while rst_n is low.
  - Any held word is discarded, including on reset mid-transfer.
- Load enable: load = !out_valid || out_ready.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, … wrapping modulo N.
  - grant is the first index with in_valid high.
  - No request means no grant.
- in_ready[grant] = load when a grant exists; all other in_ready bits are 0.
- in_ready may depend combinationally on out_ready and in_valid. No combinational path from in_data to any output.
- Capture: on a clock edge where load is high and a grant exists:
  - out_data <= in_data[grant].
  - out_sel <= grant.
  - out_valid <= 1.
  - ptr <= (grant+1) mod N; wraps from N-1 to 0.
- Drain: on an edge where load is high, no grant exists and out_valid is high, out_valid <= 0. out_data and out_sel keep their last values.
- Stall: while out_valid && !out_ready, out_data, out_sel and ptr are held stable and in_ready is all 0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle when out_ready is held high.
- Fairness: no channel with in_valid held high waits more than N-1 accepted words.
- The pointer advances only on an accepted transfer, never on idle cycles.
- Single requester: it is granted every cycle regardless of ptr.
- in_valid may drop without a handshake; the arbiter re-evaluates every cycle.

Optional Feature:
- Macro: RR_MUX_STAGE_PKT_LOCK_EN.
- Defined:
  - Adds input in_last (N bits, per channel) and output out_last (1 bit, registered with out_data; reset 0).
  - Once channel g is granted with in_last[g]=0, a lock bit sets and arbitration is forced to g until a word with in_last[g]=1 is accepted.
  - ptr advances only on that last word.
  - While locked, other channels see in_ready=0 even if g has in_valid low.
  - Reset clears the lock.
- Not defined:
  - No in_last/out_last ports.
  - Every accepted word is an independent arbitration event, as above.

Test Plan:
- Reset then idle: in_valid=0 for 5 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Single channel: in_valid=0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2; repeated every cycle.
- All request, out_ready=1: in_valid=1111 with data 8'h10,8'h11,8'h12,8'h13 -> out_sel sequence 0,1,2,3,0; one word per cycle.
- Backpressure: out_valid=1, out_data=8'h11, out_ready=0 for 3 cycles with in_valid=1111 -> out_data/out_sel unchanged and in_ready=0000. Then out_ready=1 -> next word 8'h12, out_sel=2.
- Reset mid-stall: out_valid=1 held, rst_n low for 1 cycle -> out_valid=0 immediately and ptr=0. After release with in_valid=1010, the first grant is channel 1.
- With RR_MUX_STAGE_PKT_LOCK_EN: channel 0 sends 3 words (in_last on the third) while in_valid=1111 -> out_sel=0,0,0 then 1.
